// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
//   memReq   : access request, held until memAck
//   memWe    : 1 = write, 0 = read (valid with memReq)
//   memAddr  : word address (bits [1:0] always 0)
//   memWData : store data
//   memAck   : memory completes the access this cycle
//   memRData : load data, valid with memAck
interface memory_access_if;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic        memAck;
   logic [31:0] memRData;

   modport master (
      output memReq, memWe, memAddr, memWData,
      input  memAck, memRData
   );

   modport slave (
      input  memReq, memWe, memAddr, memWData,
      output memAck, memRData
   );
endinterface

// File: rtl/memory_access.sv
// Memory stage plus MEM/WB pipeline register.
// Issues loads/stores from the EX/MEM bundle on the data-memory bus, stalls the
// upstream pipeline while an access is open, and registers the WriteBack bundle.
//
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that are not
// acknowledged within TIMEOUT_CYCLES wait cycles (sets sticky busError).
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   memControl          [0]=memRead, [1]=memWrite (both set behaves as write)
//   writeBackControlIn  [0]=memToReg, [1]=regWrite
//   resultIn            ALU result / effective address
//   storeData           store data (rt)
//   writeRegIn          destination register
//   stall               combinational hold request to the hazard unit
//   memBus              data-memory bus (master side)
//   writeBackControl, readData, result, writeReg   MEM/WB register
//   busError            sticky access-timeout flag
//
// State | meaning
// ------+----------------------------------------------------------
// IDLE  | no access open; ALU results pass through, memory ops issue
// WAIT  | memReq held, waiting for memAck (or timeout when enabled)
module memory_access #(
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] BAD_READ_DATA  = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            memControl,
   input  logic [1:0]            writeBackControlIn,
   input  logic [31:0]           resultIn,
   input  logic [31:0]           storeData,
   input  logic [4:0]            writeRegIn,
   output logic                  stall,
   memory_access_if.master       memBus,
   output logic [1:0]            writeBackControl,
   output logic [31:0]           readData,
   output logic [31:0]           result,
   output logic [4:0]            writeReg,
   output logic                  busError
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t      state, stateNext;
   logic        memOp;
   logic        stallRaw;
   logic        reqQ, reqNext;
   logic        weQ, weNext;
   logic [31:0] addrQ, addrNext;
   logic [31:0] wDataQ, wDataNext;
   logic [1:0]  wbcNext;
   logic [31:0] readDataNext, resultNext;
   logic [4:0]  writeRegNext;

`ifdef MEM_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmr, tmrNext;
   logic          busErrQ, busErrNext;
`endif

   assign memOp = memControl[0] | memControl[1];

   // Reset must pull stall low immediately even if upstream still presents a memory op.
   assign stall = stallRaw & ~reset;

   assign memBus.memReq   = reqQ;
   assign memBus.memWe    = weQ;
   assign memBus.memAddr  = addrQ;
   assign memBus.memWData = wDataQ;

`ifdef MEM_TIMEOUT_EN
   assign busError = busErrQ;
`else
   assign busError = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         reqQ             <= 1'b0;
         weQ              <= 1'b0;
         addrQ            <= '0;
         wDataQ           <= '0;
         writeBackControl <= 2'b00;
         readData         <= '0;
         result           <= '0;
         writeReg         <= '0;
`ifdef MEM_TIMEOUT_EN
         tmr              <= '0;
         busErrQ          <= 1'b0;
`endif
      end else begin
         state            <= stateNext;
         reqQ             <= reqNext;
         weQ              <= weNext;
         addrQ            <= addrNext;
         wDataQ           <= wDataNext;
         writeBackControl <= wbcNext;
         readData         <= readDataNext;
         result           <= resultNext;
         writeReg         <= writeRegNext;
`ifdef MEM_TIMEOUT_EN
         tmr              <= tmrNext;
         busErrQ          <= busErrNext;
`endif
      end
   end

   always_comb begin
      stateNext    = state;
      stallRaw     = 1'b0;
      reqNext      = reqQ;
      weNext       = weQ;
      addrNext     = addrQ;
      wDataNext    = wDataQ;
      wbcNext      = 2'b00;
      readDataNext = readData;
      resultNext   = result;
      writeRegNext = writeReg;
`ifdef MEM_TIMEOUT_EN
      tmrNext      = tmr;
      busErrNext   = busErrQ;
`endif
      case (state)
         S_IDLE: begin
            if (memOp) begin
               stallRaw  = 1'b1;
               reqNext   = 1'b1;
               weNext    = memControl[1];
               addrNext  = {resultIn[31:2], 2'b00};
               wDataNext = storeData;
               stateNext = S_WAIT;
`ifdef MEM_TIMEOUT_EN
               // Down-counter: terminal count 0 marks the last allowed wait cycle.
               tmrNext   = TW'(TIMEOUT_CYCLES - 1);
`endif
            end else begin
               wbcNext      = writeBackControlIn;
               resultNext   = resultIn;
               writeRegNext = writeRegIn;
            end
         end
         S_WAIT: begin
            if (memBus.memAck) begin
               reqNext      = 1'b0;
               stateNext    = S_IDLE;
               wbcNext      = writeBackControlIn;
               resultNext   = resultIn;
               writeRegNext = writeRegIn;
               if (!weQ) readDataNext = memBus.memRData;
            end else begin
`ifdef MEM_TIMEOUT_EN
               if (tmr == '0) begin
                  // Abort: release the pipeline with the write suppressed.
                  reqNext      = 1'b0;
                  stateNext    = S_IDLE;
                  busErrNext   = 1'b1;
                  readDataNext = BAD_READ_DATA;
                  resultNext   = resultIn;
                  writeRegNext = writeRegIn;
               end else begin
                  stallRaw = 1'b1;
                  tmrNext  = tmr - 1'b1;
               end
`else
               stallRaw = 1'b1;
`endif
            end
         end
         default: stateNext = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

   typedef struct packed {
      logic [1:0]  wbc;
      logic [31:0] rd;
      logic [31:0] res;
      logic [4:0]  wr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  memControl = 2'b00;
   logic [1:0]  wbcIn = 2'b00;
   logic [31:0] resultIn = '0;
   logic [31:0] storeData = '0;
   logic [4:0]  writeRegIn = '0;
   logic        stall;
   logic [1:0]  writeBackControl;
   logic [31:0] readData, result;
   logic [4:0]  writeReg;
   logic        busError;

   memory_access_if bus ();

   memory_access #(.TIMEOUT_CYCLES(4), .BAD_READ_DATA(32'hDEADBEEF)) dut (
      .clk                (clk),
      .reset              (reset),
      .memControl         (memControl),
      .writeBackControlIn (wbcIn),
      .resultIn           (resultIn),
      .storeData          (storeData),
      .writeRegIn         (writeRegIn),
      .stall              (stall),
      .memBus             (bus),
      .writeBackControl   (writeBackControl),
      .readData           (readData),
      .result             (result),
      .writeReg           (writeReg),
      .busError           (busError)
   );

   always #5 clk = ~clk;

   int   tests = 0;
   int   fails = 0;
   exp_t expQ[$];
   logic [31:0] mdlRead = '0;
   bit   monOn = 0;
   bit   retirePend = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: an instruction retires on the edge after a non-stalled
   // cycle; its MEM/WB bundle is visible in the following cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (monOn) begin
            if (retirePend) begin
               if (expQ.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL retireNoExpect: got wbc %b expected none", writeBackControl);
               end else begin
                  e = expQ.pop_front();
                  chk("wbc", {30'd0, writeBackControl}, {30'd0, e.wbc});
                  chk("readData", readData, e.rd);
                  chk("result", result, e.res);
                  chk("writeReg", {27'd0, writeReg}, {27'd0, e.wr});
               end
            end else begin
               chk("bubble", {30'd0, writeBackControl}, 32'd0);
            end
            retirePend = !stall;
         end
      end
   end

   task automatic busChk(input bit isWr, input logic [31:0] res, input logic [31:0] sd,
                         input logic expStall);
      chk("memReq", {31'd0, bus.memReq}, 32'd1);
      chk("memAddr", bus.memAddr, res & 32'hFFFF_FFFC);
      chk("memWe", {31'd0, bus.memWe}, {31'd0, isWr});
      if (isWr) chk("memWData", bus.memWData, sd);
      chk("stallWait", {31'd0, stall}, {31'd0, expStall});
   endtask

   // kind: 0 ALU, 1 load, 2 store, 3 both bits set (acts as store)
   task automatic issue(input int kind, input logic [1:0] wbc, input logic [31:0] res,
                        input logic [31:0] sd, input logic [4:0] wr, input int delay,
                        input logic [31:0] rdata);
      bit isWr;
      isWr       = (kind >= 2);
      memControl = (kind == 0) ? 2'b00 : (kind == 1) ? 2'b01 : (kind == 2) ? 2'b10 : 2'b11;
      wbcIn      = wbc;
      resultIn   = res;
      storeData  = sd;
      writeRegIn = wr;
      bus.memAck   = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.memRData = $urandom;
      if (kind == 1) mdlRead = rdata;
      expQ.push_back('{wbc, mdlRead, res, wr});
      if (kind == 0) begin
         @(negedge clk);
         chk("stallAlu", {31'd0, stall}, 32'd0);
         @(posedge clk); #1;
         bus.memAck = 1'b0;
      end else begin
         @(negedge clk);
         chk("stallIssue", {31'd0, stall}, 32'd1);
         chk("reqGap", {31'd0, bus.memReq}, 32'd0);
         @(posedge clk); #1;
         for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            busChk(isWr, res, sd, 1'b1);
            @(posedge clk); #1;
         end
         bus.memAck   = 1'b1;
         bus.memRData = rdata;
         @(negedge clk);
         busChk(isWr, res, sd, 1'b0);
         @(posedge clk); #1;
         bus.memAck = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.memAck   = 1'b0;
      bus.memRData = '0;
      #12;
      chk("rstReq", {31'd0, bus.memReq}, 32'd0);
      chk("rstWbc", {30'd0, writeBackControl}, 32'd0);
      chk("rstReadData", readData, 32'd0);
      chk("rstResult", result, 32'd0);
      chk("rstWriteReg", {27'd0, writeReg}, 32'd0);
      chk("rstBusError", {31'd0, busError}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of an open access.
      memControl = 2'b01; resultIn = 32'h100;
      @(posedge clk); #1;
      chk("waitReq", {31'd0, bus.memReq}, 32'd1);
      reset = 1'b1; #1;
      chk("midRstReq", {31'd0, bus.memReq}, 32'd0);
      chk("midRstStall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; memControl = 2'b00; wbcIn = 2'b11; resultIn = 32'h55;
      @(negedge clk);
      chk("postRstReq", {31'd0, bus.memReq}, 32'd0);
      chk("postRstStall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("preRstWbc", {30'd0, writeBackControl}, 32'd3);
      reset = 1'b1; #1;
      chk("rstWbcAsync", {30'd0, writeBackControl}, 32'd0);
      chk("rstResAsync", result, 32'd0);
      wbcIn = 2'b00;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      mdlRead = '0;

      monOn = 1; retirePend = 0;
      issue(0, 2'b10, 32'h0000_0012, 32'h0, 5'd5, 0, 32'h0);
      issue(1, 2'b11, 32'h0000_0043, 32'h0, 5'd7, 3, 32'hCAFE_F00D);
      issue(2, 2'b00, 32'h0000_0080, 32'h1234_5678, 5'd0, 0, 32'h0);
      issue(1, 2'b11, 32'h0000_0104, 32'h0, 5'd9, 0, 32'h1111_2222);
      issue(2, 2'b00, 32'h0000_0107, 32'hAAAA_5555, 5'd0, 0, 32'h0);
      issue(3, 2'b01, 32'h0000_0200, 32'h0BAD_F00D, 5'd3, 1, 32'h3333_4444);
      for (int n = 0; n < 60; n++) begin
         issue(int'($urandom_range(0, 3)), 2'($urandom), $urandom, $urandom,
               5'($urandom), int'($urandom_range(0, 3)), $urandom);
      end
      memControl = 2'b00;
      @(negedge clk); #1;
      monOn = 0; retirePend = 0;
      chk("queueEmpty", expQ.size(), 32'd0);
      @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
      memControl = 2'b01; resultIn = 32'h0000_0200; writeRegIn = 5'd4; wbcIn = 2'b11;
      @(negedge clk);
      chk("toIssueStall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("toWaitStall", {31'd0, stall}, (i < 3) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end
      memControl = 2'b00;
      @(negedge clk);
      chk("toBusError", {31'd0, busError}, 32'd1);
      chk("toReadData", readData, 32'hDEADBEEF);
      chk("toWbc", {30'd0, writeBackControl}, 32'd0);
      chk("toReq", {31'd0, bus.memReq}, 32'd0);
      chk("toWriteReg", {27'd0, writeReg}, 32'd4);
      @(posedge clk); #1;
      @(negedge clk);
      chk("toSticky", {31'd0, busError}, 32'd1);
`else
      chk("busErrorTied", {31'd0, busError}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
